// File: rtl/pa_pkg.sv
// Shared definitions for the 3x3 output-stationary systolic array.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: array dimension, default operand/accumulator widths, drain length,
// operand/accumulator typedefs and the array controller state encoding.
package pa_pkg;
  localparam int N          = 3;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;
  // Last vector needs 2N-1 edges to sweep from PE(0,0) to PE(N-1,N-1) and settle.
  localparam int DRAIN_LEN  = 2*N - 1;

  typedef logic signed [DATA_W_DEF-1:0] operand_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } pa_state_e;
endpackage

// File: rtl/pa_mac_pe.sv
// Single systolic PE: signed multiply-accumulate with registered right/down operand forwarding.
// Latency: operands forwarded after 1 cycle; accumulator updates on every edge.
// Backpressure: none; upstream injects zero operands for idle cycles.
// Ports: clk, clr (sync clear of acc and forward regs), a/b (operands in),
//        a_fwd/b_fwd (operands to right/lower neighbour), acc (running sum),
//        ovf_hit (signed overflow on this cycle's add).
// Config macro: PA_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module pa_mac_pe
  import pa_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] a_fwd,
  output logic signed [DATA_W-1:0] b_fwd,
  output logic signed [ACC_W-1:0]  acc,
  output logic                     ovf_hit
);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic signed [ACC_W-1:0]    acc_n;

  always_comb begin
    prod     = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    prod_ext = ACC_W'(prod);
    sum      = acc + prod_ext;
    // Same-sign operands producing a result of the other sign.
    ovf_hit  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
`ifdef PA_SATURATE_EN
    if (ovf_hit) begin
      // Clamp toward the sign both operands shared.
      acc_n = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_n = sum;
    end
`else
    acc_n = sum;
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc   <= '0;
      a_fwd <= '0;
      b_fwd <= '0;
    end else begin
      acc   <= acc_n;
      a_fwd <= a;
      b_fwd <= b;
    end
  end

endmodule

// File: rtl/processing_array_3x3.sv
// 3x3 output-stationary systolic matrix multiply: C += A x B over K_STEPS column/row vector pairs.
// Latency: o_computation_done rises 5 edges after the edge accepting the last vector.
// Backpressure: o_ready_for_data low during DRAIN/DONE; valid is ignored while not ready.
// Ports: clk, i_reset (sync, active-high), i_a_vector/i_b_vector (packed operand vectors),
//        i_data_valid, i_read_enable (leave DONE), i_clear_acc (sync clear),
//        o_result_matrix (packed accumulators), o_computation_done, o_ready_for_data,
//        o_overflow_detected (sticky).
// Config macro: PA_SATURATE_EN (saturating accumulators, passed to pa_mac_pe).
module processing_array_3x3
  import pa_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int K_STEPS = 3
) (
  input  logic                 clk,
  input  logic                 i_reset,
  input  logic [N*DATA_W-1:0]  i_a_vector,
  input  logic [N*DATA_W-1:0]  i_b_vector,
  input  logic                 i_data_valid,
  input  logic                 i_read_enable,
  input  logic                 i_clear_acc,
  output logic [N*N*ACC_W-1:0] o_result_matrix,
  output logic                 o_computation_done,
  output logic                 o_ready_for_data,
  output logic                 o_overflow_detected
);

  localparam int CW = $clog2(K_STEPS + 1);

  pa_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    drain_cnt, drain_n;
  logic          clr;
  logic          accept;

  logic signed [DATA_W-1:0] a_g [N];
  logic signed [DATA_W-1:0] b_g [N];
  logic signed [DATA_W-1:0] a_h [N][N+1];
  logic signed [DATA_W-1:0] b_v [N+1][N];
  logic [N*N-1:0]           pe_ovf;
  logic                     edge_unused;

  assign clr                = i_reset | i_clear_acc;
  assign o_ready_for_data   = ((state == IDLE) || (state == LOAD)) && (cnt < CW'(K_STEPS));
  assign o_computation_done = (state == DONE);
  assign accept             = i_data_valid && o_ready_for_data;

  // Non-accepted cycles feed zeros so bubbles contribute nothing.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_g[i] = accept ? i_a_vector[DATA_W*i +: DATA_W] : '0;
      b_g[i] = accept ? i_b_vector[DATA_W*i +: DATA_W] : '0;
    end
  end

  // Row i / column j operands are delayed i / j cycles so matching k meet in each PE.
  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign a_h[0][0] = a_g[0];
      assign b_v[0][0] = b_g[0];
    end else begin : g_pipe
      logic signed [DATA_W-1:0] a_pipe [gi];
      logic signed [DATA_W-1:0] b_pipe [gi];
      always_ff @(posedge clk) begin
        if (clr) begin
          for (int d = 0; d < gi; d++) begin
            a_pipe[d] <= '0;
            b_pipe[d] <= '0;
          end
        end else begin
          a_pipe[0] <= a_g[gi];
          b_pipe[0] <= b_g[gi];
          for (int d = 1; d < gi; d++) begin
            a_pipe[d] <= a_pipe[d-1];
            b_pipe[d] <= b_pipe[d-1];
          end
        end
      end
      assign a_h[gi][0] = a_pipe[gi-1];
      assign b_v[0][gi] = b_pipe[gi-1];
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic signed [ACC_W-1:0] acc_q;
      pa_mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
        .clk     (clk),
        .clr     (clr),
        .a       (a_h[gi][gj]),
        .b       (b_v[gi][gj]),
        .a_fwd   (a_h[gi][gj+1]),
        .b_fwd   (b_v[gi+1][gj]),
        .acc     (acc_q),
        .ovf_hit (pe_ovf[gi*N+gj])
      );
      assign o_result_matrix[ACC_W*(N*gi+gj) +: ACC_W] = acc_q;
    end
  end

  // Operands leaving the right/bottom edge of the array have no consumer.
  always_comb begin
    edge_unused = 1'b0;
    for (int i = 0; i < N; i++) begin
      edge_unused = edge_unused ^ (^a_h[i][N]) ^ (^b_v[N][i]);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    drain_n = drain_cnt;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          cnt_n = cnt + CW'(1);
          if (cnt_n == CW'(K_STEPS)) begin
            state_n = DRAIN;
            drain_n = '0;
          end else begin
            state_n = LOAD;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == 3'(DRAIN_LEN - 1)) begin
          state_n = DONE;
        end else begin
          drain_n = drain_cnt + 3'd1;
        end
      end
      DONE: begin
        if (i_read_enable) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state               <= IDLE;
      cnt                 <= '0;
      drain_cnt           <= '0;
      o_overflow_detected <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      drain_cnt           <= drain_n;
      o_overflow_detected <= o_overflow_detected | (|pe_ovf);
    end
  end

endmodule

// File: tb/tb_processing_array_3x3.sv
// Directed bench for processing_array_3x3: a 32-bit and a 16-bit accumulator instance share stimulus.
// Latency: checks done rising 5 edges after the last accepted vector.
// Backpressure: checks ready during gaps, drain and done.
module tb_processing_array_3x3;
  logic        clk;
  logic        i_reset;
  logic [23:0] i_a_vector;
  logic [23:0] i_b_vector;
  logic        i_data_valid;
  logic        i_read_enable;
  logic        i_clear_acc;
  logic [287:0] res32;
  logic [143:0] res16;
  logic        done32, rdy32, ovf32;
  logic        done16, rdy16, ovf16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [23:0] a_id  [3] = '{24'h000001, 24'h000100, 24'h010000};
  logic [23:0] b_id  [3] = '{24'h030201, 24'h060504, 24'h090807};
  logic [23:0] a_neg [3] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
  logic [23:0] b_two [3] = '{24'h020202, 24'h020202, 24'h020202};
  logic [23:0] a_big [3] = '{24'h7F7F7F, 24'h7F7F7F, 24'h7F7F7F};

  processing_array_3x3 dut (
    .clk(clk), .i_reset(i_reset), .i_a_vector(i_a_vector), .i_b_vector(i_b_vector),
    .i_data_valid(i_data_valid), .i_read_enable(i_read_enable), .i_clear_acc(i_clear_acc),
    .o_result_matrix(res32), .o_computation_done(done32), .o_ready_for_data(rdy32),
    .o_overflow_detected(ovf32)
  );

  processing_array_3x3 #(.ACC_W(16)) dut16 (
    .clk(clk), .i_reset(i_reset), .i_a_vector(i_a_vector), .i_b_vector(i_b_vector),
    .i_data_valid(i_data_valid), .i_read_enable(i_read_enable), .i_clear_acc(i_clear_acc),
    .o_result_matrix(res16), .o_computation_done(done16), .o_ready_for_data(rdy16),
    .o_overflow_detected(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] c32(input int i, input int j);
    return res32[32*(3*i+j) +: 32];
  endfunction

  function automatic logic [15:0] c16(input int i, input int j);
    return res16[16*(3*i+j) +: 16];
  endfunction

  // Feed three vectors with `gap` idle cycles between them, then wait for done.
  task automatic run3(input logic [23:0] av[3], input logic [23:0] bv[3], input int gap,
                      input string tag);
    int n;
    for (int k = 0; k < 3; k++) begin
      i_data_valid = 1'b1;
      i_a_vector   = av[k];
      i_b_vector   = bv[k];
      step();
      i_data_valid = 1'b0;
      i_a_vector   = '0;
      i_b_vector   = '0;
      if (k < 2) begin
        for (int g = 0; g < gap; g++) begin
          chk({tag, "_gap_ready"}, rdy32, 1);
          step();
        end
      end
    end
    chk({tag, "_drain_ready"}, rdy32, 0);
    n = 0;
    while (!done32 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 5);
  endtask

  task automatic read_out();
    i_read_enable = 1'b1;
    step();
    i_read_enable = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear_acc = 1'b1;
    step();
    i_clear_acc = 1'b0;
  endtask

  initial begin
    logic [15:0] big16;
    i_reset = 1'b1; i_a_vector = '0; i_b_vector = '0;
    i_data_valid = 1'b0; i_read_enable = 1'b0; i_clear_acc = 1'b0;
    step(); step();
    i_reset = 1'b0;
    step();

    chk("rst_done", done32, 0);
    chk("rst_ovf", ovf32, 0);
    chk("rst_ready", rdy32, 1);
    chk("rst_result", |res32, 0);

    // Identity A selects rows of B.
    run3(a_id, b_id, 0, "t1");
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("t1_c%0d%0d", i, j), c32(i, j), 3*i+j+1);
    chk("t1_ovf", ovf32, 0);
    chk("t1_ovf16", ovf16, 0);
    chk("t1_done_ready", rdy32, 0);
    read_out();
    chk("t1_read_done", done32, 0);
    chk("t1_read_ready", rdy32, 1);

    // Second pass without clear accumulates on top.
    run3(a_id, b_id, 0, "t4");
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("t4_c%0d%0d", i, j), c32(i, j), 2*(3*i+j+1));
    // Valid while in DONE must be ignored.
    i_data_valid = 1'b1; i_a_vector = 24'h010101; i_b_vector = 24'h010101;
    step();
    i_data_valid = 1'b0; i_a_vector = '0; i_b_vector = '0;
    repeat (6) step();
    chk("t4_done_ignore_c22", c32(2, 2), 18);
    chk("t4_done_ignore_c00", c32(0, 0), 2);
    chk("t4_still_done", done32, 1);
    read_out();
    pulse_clear();
    chk("t4_clr_result", |res32, 0);
    chk("t4_clr_ready", rdy32, 1);
    chk("t4_clr_done", done32, 0);
    // Read enable outside DONE does nothing.
    read_out();
    chk("t4_idle_read_ready", rdy32, 1);
    chk("t4_idle_read_done", done32, 0);

    // Bubbles between vectors.
    run3(a_id, b_id, 2, "t3");
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("t3_c%0d%0d", i, j), c32(i, j), 3*i+j+1);
    read_out();
    pulse_clear();

    // Signed: (-1)*2 summed over 3 steps.
    run3(a_neg, b_two, 0, "t2");
    chk("t2_c00", c32(0, 0), 32'hFFFFFFFA);
    chk("t2_c12", c32(1, 2), 32'hFFFFFFFA);
    chk("t2_c22", c32(2, 2), 32'hFFFFFFFA);
    chk("t2_c16_21", c16(2, 1), 16'hFFFA);
    chk("t2_ovf", ovf32, 0);
    read_out();
    pulse_clear();

    // 3*127*127 = 48387 overflows a signed 16-bit accumulator.
`ifdef PA_SATURATE_EN
    big16 = 16'h7FFF;
`else
    big16 = 16'(3*127*127);
`endif
    run3(a_big, a_big, 0, "t5");
    chk("t5_ovf16", ovf16, 1);
    chk("t5_c16_00", c16(0, 0), big16);
    chk("t5_c16_22", c16(2, 2), big16);
    chk("t5_ovf32", ovf32, 0);
    chk("t5_c32_11", c32(1, 1), 3*127*127);
    read_out();

    // Reset in the middle of DRAIN.
    for (int k = 0; k < 3; k++) begin
      i_data_valid = 1'b1; i_a_vector = a_id[k]; i_b_vector = b_id[k];
      step();
    end
    i_data_valid = 1'b0; i_a_vector = '0; i_b_vector = '0;
    step(); step();
    chk("t6_pre_ready", rdy32, 0);
    chk("t6_pre_ovf16", ovf16, 1);
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("t6_ready", rdy32, 1);
    chk("t6_done", done32, 0);
    chk("t6_ovf16", ovf16, 0);
    chk("t6_result", |res32, 0);
    chk("t6_result16", |res16, 0);
    repeat (8) step();
    chk("t6_no_late_done", done32, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
